// File: rtl/fifo_write_arbiter.sv
// Burst-based round-robin arbiter that funnels NUM_REQ requesters into one FIFO write port.
// Define FIFO_WRITE_ARBITER_TAG_EN to prepend the owner index above each data word.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          Clk,
    input  logic                          Clear_in,
    input  logic [NUM_REQ-1:0]            Req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_data_in,
    output logic [NUM_REQ-1:0]            Req_ready_out,
`ifdef FIFO_WRITE_ARBITER_TAG_EN
    output logic [DATA_WIDTH+$clog2(NUM_REQ)-1:0] Fifo_data_out,
`else
    output logic [DATA_WIDTH-1:0]         Fifo_data_out,
`endif
    output logic                          Fifo_writeEn_out,
    input  logic                          Fifo_full_in,
    output logic [NUM_REQ-1:0]            Grant_out,
    output logic                          Busy_out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     lastOwner_q, lastOwner_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ID_W-1:0]     pick, cand;
    logic                found;
    logic                active, ownerValid, transfer;
    logic [DATA_WIDTH-1:0] ownerData;

    // Round-robin search starting just above the previous owner.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(lastOwner_q) + i) % NUM_REQ);
            if (!found && Req_valid_in[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Clear_in masks the outputs in the same cycle so an abandoned burst writes nothing more.
    assign active     = (state_q == GRANT) && !Clear_in;
    assign ownerValid = Req_valid_in[owner_q];
    assign ownerData  = Req_data_in[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign transfer   = active && ownerValid && !Fifo_full_in;

    always_comb begin
        Busy_out         = active;
        Fifo_writeEn_out = transfer;
        Grant_out        = '0;
        Req_ready_out    = '0;
        Fifo_data_out    = '0;
        if (active) begin
            Grant_out = NUM_REQ'(1) << owner_q;
            if (!Fifo_full_in) begin
                Req_ready_out = NUM_REQ'(1) << owner_q;
            end
`ifdef FIFO_WRITE_ARBITER_TAG_EN
            Fifo_data_out = {owner_q, ownerData};
`else
            Fifo_data_out = ownerData;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    owner_d = pick;
                    count_d = '0;
                end
            end
            GRANT: begin
                if (!ownerValid) begin
                    state_d     = IDLE;
                    lastOwner_d = owner_q;
                    count_d     = '0;
                end else if (!Fifo_full_in) begin
                    if (count_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d     = IDLE;
                        lastOwner_d = owner_q;
                        count_d     = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // lastOwner resets to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= ID_W'(NUM_REQ - 1);
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each requester's data word.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter BURST_LEN, default 4, maximum words per grant; legal range 1..16.
REQ-004 Clk  input  1  single clock; the same clock as the FIFO write port.
REQ-005 Clear_in  input  1  reset; synchronous, active-high.
REQ-006 Req_valid_in  input  NUM_REQ  per-requester word-valid.
REQ-007 Req_data_in  input  NUM_REQ*DATA_WIDTH  packed requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Req_ready_out  output  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high at a Clk edge.
REQ-009 Fifo_data_out  output  DATA_WIDTH (+ID_W with tag option)  data to the FIFO Data_in.
REQ-010 Fifo_writeEn_out  output  1  drives the FIFO WriteEn_in.
REQ-011 Fifo_full_in  input  1  FIFO Full_out.
REQ-012 Grant_out  output  NUM_REQ  one-hot current owner; all zero when no owner.
REQ-013 Busy_out  output  1  high while in GRANT state.

Function
REQ-014 FSM states SHALL be IDLE and GRANT only.
REQ-015 In IDLE with any Req_valid_in bit high, the SHALL select the first valid requester searching upward, with wrap-around, from (last_owner+1) mod NUM_REQ; it SHALL then enter GRANT next cycle with Grant_out one-hot and burst count 0.
REQ-016 In IDLE no ready, no write and Grant_out zero; every grant is preceded by exactly one IDLE cycle (arbitration bubble).
REQ-017 In GRANT, for owner g: Req_ready_out[g] = ~Fifo_full_in; all other ready bits are 0 (combinational from Fifo_full_in).
REQ-018 Fifo_writeEn_out SHALL equal Req_valid_in[g] & ~Fifo_full_in in GRANT, else 0; Fifo_data_out SHALL be owner g's data word in the same cycle (zero added latency).
REQ-019 Each transfer SHALL increment the burst count; the count SHALL NOT change while Fifo_full_in is high.
REQ-020 GRANT SHALL release to IDLE and record last_owner = g when a transfer completes with count = BURST_LEN-1.
REQ-021 GRANT SHALL also release when Req_valid_in[g] is low in a cycle, regardless of Fifo_full_in.
REQ-022 With Fifo_full_in high and Req_valid_in[g] high, grant and count SHALL hold indefinitely.
REQ-023 Requester valids may change freely. Only the owner's valid affects GRANT.
REQ-024 The block SHALL never assert Fifo_writeEn_out while Fifo_full_in is high.

Reset
REQ-025 Clear_in high at a Clk edge SHALL force IDLE, burst count 0, last_owner = NUM_REQ-1 (so requester 0 wins first), overriding any transfer that cycle.
REQ-026 During and after reset, until next grant: Req_ready_out = 0, Fifo_writeEn_out = 0, Grant_out = 0, Busy_out = 0, Fifo_data_out = 0.
REQ-027 Clear_in mid-burst SHALL abandon the burst with no further writes; words already written stay in the FIFO (FIFO clear is the system's responsibility).

Configuration
REQ-028 Macro FIFO_WRITE_ARBITER_TAG_EN: when defined, Fifo_data_out SHALL be DATA_WIDTH+ID_W bits, ID_W = clog2(NUM_REQ), with owner index g in the top ID_W bits above the data; when undefined, Fifo_data_out SHALL be DATA_WIDTH bits of data only.

Verification
REQ-029 Reset, then requesters 0 and 2 held valid, full low, BURST_LEN=4 -> 1 bubble, then 4 writes from req 0, 1 bubble, then 4 writes from req 2, then req 0 again.
REQ-030 All 4 valid continuously -> grant order 0,1,2,3,0; each burst exactly 4 words; no write cycle in a bubble.
REQ-031 Req 1 granted, Fifo_full_in high for 5 cycles after its 2nd word -> ready and writeEn low for 5 cycles, grant held, then 2 more words, then release.
REQ-032 Req 3 granted, drops valid after 1 word -> release next edge; last_owner=3; next grant goes to lowest valid of 0,1,2.
REQ-033 Clear_in pulsed mid-burst of req 2 -> next cycle IDLE, all outputs 0; with all valid, next grant is req 0.
REQ-034 With FIFO_WRITE_ARBITER_TAG_EN, NUM_REQ=4, req 2 writes 0xA5 -> Fifo_data_out = 10'b10_1010_0101; without it, 8'hA5.
